ofdm_tx_frame_ctrl: RTL and testbench

- Frame sequencer between the bit-symbol source and the input port of OFDM_TX_802_11.
- Per frame: latches a length, forwards exactly that many 6-bit symbols over the Wishbone-style handshake, and optionally zero-pads to a whole OFDM symbol.
- Then holds off until the transmitter's output cycle (CYC_O of OFDM_TX_802_11) has ended, and enforces an inter-frame gap before accepting the next START.

---
 rtl/ofdm_tx_frame_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ofdm_tx_frame_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_tx_frame_ctrl.sv
// Frame sequencer feeding OFDM_TX_802_11: length-framed pass-through, drain, gap.
// Optional zero padding to whole OFDM symbols: define OFDM_TX_FRAME_PAD_EN.
module ofdm_tx_frame_ctrl #(
    parameter int SYM_BITS = 48,
    parameter int GAP_CYC  = 32,
    parameter int LEN_W    = 16
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic             START_I,
    input  logic [LEN_W-1:0] FRM_LEN_I,
    input  logic [5:0]       DAT_I,
    input  logic             WE_I,
    input  logic             STB_I,
    input  logic             CYC_I,
    output logic             ACK_O,
    output logic [5:0]       DAT_O,
    output logic             WE_O,
    output logic             STB_O,
    output logic             CYC_O,
    input  logic             ACK_I,
    input  logic             TX_CYC_I,
    output logic             BUSY_O,
    output logic             DONE_O,
    output logic [LEN_W-1:0] FRM_CNT_O
);

    typedef enum logic [2:0] {
        IDLE,
        PASS,
`ifdef OFDM_TX_FRAME_PAD_EN
        PAD,
`endif
        DRAIN,
        GAP
    } state_t;

    localparam logic [LEN_W-1:0] ONE    = LEN_W'(1);
    localparam logic [LEN_W-1:0] GAP_LD = LEN_W'(GAP_CYC);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] wcnt_q, wcnt_d;
    logic [LEN_W-1:0] gcnt_q, gcnt_d;
    logic [LEN_W-1:0] frm_cnt_q, frm_cnt_d;
    logic             tx_cyc_q;
    logic             up_req;
    logic             tx_fall;

`ifdef OFDM_TX_FRAME_PAD_EN
    logic [LEN_W-1:0] pad_q, pad_d;
    logic [LEN_W-1:0] pcnt_q, pcnt_d;

    // Zero words needed to round len up to a whole OFDM symbol.
    function automatic logic [LEN_W-1:0] pad_of(input logic [LEN_W-1:0] len);
        int unsigned rem;
        rem    = 32'(len) % 32'(SYM_BITS);
        pad_of = LEN_W'((32'(SYM_BITS) - rem) % 32'(SYM_BITS));
    endfunction
`endif

    assign up_req    = STB_I & CYC_I;
    assign tx_fall   = tx_cyc_q & ~TX_CYC_I;
    assign BUSY_O    = (state_q != IDLE);
    assign FRM_CNT_O = frm_cnt_q;

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        wcnt_d    = wcnt_q;
        gcnt_d    = gcnt_q;
        frm_cnt_d = frm_cnt_q;
`ifdef OFDM_TX_FRAME_PAD_EN
        pad_d     = pad_q;
        pcnt_d    = pcnt_q;
`endif
        ACK_O     = 1'b0;
        DAT_O     = '0;
        WE_O      = 1'b0;
        STB_O     = 1'b0;
        CYC_O     = 1'b0;
        DONE_O    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (START_I && FRM_LEN_I != '0) begin
                    len_d   = FRM_LEN_I;
                    wcnt_d  = '0;
`ifdef OFDM_TX_FRAME_PAD_EN
                    pad_d   = pad_of(FRM_LEN_I);
                    pcnt_d  = '0;
`endif
                    state_d = PASS;
                end
            end
            PASS: begin
                CYC_O = 1'b1;
                STB_O = up_req;
                WE_O  = WE_I & up_req;
                DAT_O = DAT_I;
                ACK_O = ACK_I & up_req;
                if (up_req && ACK_I) begin
                    wcnt_d = wcnt_q + ONE;
                    if (wcnt_q == len_q - ONE) begin
`ifdef OFDM_TX_FRAME_PAD_EN
                        state_d = (pad_q != '0) ? PAD : DRAIN;
`else
                        state_d = DRAIN;
`endif
                    end
                end
            end
`ifdef OFDM_TX_FRAME_PAD_EN
            PAD: begin
                CYC_O = 1'b1;
                STB_O = 1'b1;
                WE_O  = 1'b1;
                if (ACK_I) begin
                    pcnt_d = pcnt_q + ONE;
                    if (pcnt_q == pad_q - ONE) begin
                        state_d = DRAIN;
                    end
                end
            end
`endif
            DRAIN: begin
                // Wait for the transmitter to finish putting the frame on air.
                if (tx_fall) begin
                    if (GAP_CYC == 0) begin
                        DONE_O    = 1'b1;
                        frm_cnt_d = frm_cnt_q + ONE;
                        state_d   = IDLE;
                    end else begin
                        gcnt_d  = GAP_LD;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                gcnt_d = gcnt_q - ONE;
                if (gcnt_q == ONE) begin
                    DONE_O    = 1'b1;
                    frm_cnt_d = frm_cnt_q + ONE;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q   <= IDLE;
            len_q     <= '0;
            wcnt_q    <= '0;
            gcnt_q    <= '0;
            frm_cnt_q <= '0;
            tx_cyc_q  <= 1'b0;
`ifdef OFDM_TX_FRAME_PAD_EN
            pad_q     <= '0;
            pcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wcnt_q    <= wcnt_d;
            gcnt_q    <= gcnt_d;
            frm_cnt_q <= frm_cnt_d;
            tx_cyc_q  <= TX_CYC_I;
`ifdef OFDM_TX_FRAME_PAD_EN
            pad_q     <= pad_d;
            pcnt_q    <= pcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_ofdm_tx_frame_ctrl.sv
// Randomized self-checking bench for ofdm_tx_frame_ctrl against a frame-level model.
// A second narrow instance (LEN_W=4, GAP_CYC=0) exercises frame counter wrap.
module tb_ofdm_tx_frame_ctrl;

    localparam int G = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_frm = 0;

    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [15:0] len_i = '0;
    logic [5:0]  dat_i = '0;
    logic        we_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        cyc_i = 1'b0;
    logic        ack_i = 1'b0;
    logic        tx_cyc_i = 1'b0;
    logic        ack_o, we_o, stb_o, cyc_o, busy_o, done_o;
    logic [5:0]  dat_o;
    logic [15:0] frm_cnt_o;

    logic        w_rst = 1'b1;
    logic        w_start = 1'b0;
    logic [3:0]  w_len = '0;
    logic [5:0]  w_dat = '0;
    logic        w_stb = 1'b0;
    logic        w_tx = 1'b0;
    logic        w_ack_o, w_we_o, w_stb_o, w_cyc_o, w_busy_o, w_done_o;
    logic [5:0]  w_dat_o;
    logic [3:0]  w_frm_o;

    ofdm_tx_frame_ctrl #(.SYM_BITS(48), .GAP_CYC(G), .LEN_W(16)) dut (
        .CLK_I(clk), .RST_I(rst_i), .START_I(start_i), .FRM_LEN_I(len_i),
        .DAT_I(dat_i), .WE_I(we_i), .STB_I(stb_i), .CYC_I(cyc_i),
        .ACK_O(ack_o), .DAT_O(dat_o), .WE_O(we_o), .STB_O(stb_o),
        .CYC_O(cyc_o), .ACK_I(ack_i), .TX_CYC_I(tx_cyc_i),
        .BUSY_O(busy_o), .DONE_O(done_o), .FRM_CNT_O(frm_cnt_o)
    );

    ofdm_tx_frame_ctrl #(.SYM_BITS(1), .GAP_CYC(0), .LEN_W(4)) dut_wrap (
        .CLK_I(clk), .RST_I(w_rst), .START_I(w_start), .FRM_LEN_I(w_len),
        .DAT_I(w_dat), .WE_I(w_stb), .STB_I(w_stb), .CYC_I(w_stb),
        .ACK_O(w_ack_o), .DAT_O(w_dat_o), .WE_O(w_we_o), .STB_O(w_stb_o),
        .CYC_O(w_cyc_o), .ACK_I(1'b1), .TX_CYC_I(w_tx),
        .BUSY_O(w_busy_o), .DONE_O(w_done_o), .FRM_CNT_O(w_frm_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    function automatic int pad_of(input int l);
`ifdef OFDM_TX_FRAME_PAD_EN
        return (48 - l % 48) % 48;
`else
        return 0;
`endif
    endfunction

    // One frame: len data words plus model padding must appear downstream in order,
    // DONE_O must land G cycles after the TX_CYC_I fall, BUSY_O spans START..DONE.
    task automatic run_frame(input int len, input int ack_at, input int ack_n,
                             input int stb_at, input int stb_n, input int rst_at,
                             input bit ign, input bit rnd);
        logic [5:0] exp_q[$];
        int tot, up, rx, s, k, d, dly, tcnt, busy_n, ack_hold, stb_hold, phase;
        bit ack_done, stb_done, cyc_drop, rst_now, chk_fall;
        tot = len + pad_of(len);
        for (int i = 0; i < tot; i++) begin
            if (i < len) exp_q.push_back(6'($urandom));
            else exp_q.push_back(6'd0);
        end
        up = 0; rx = 0; k = -1; d = -1; dly = $urandom_range(0, 5);
        tcnt = 0; busy_n = 0; ack_hold = 0; stb_hold = 0; phase = 0;
        ack_done = 0; stb_done = 0; cyc_drop = 0; rst_now = 0; chk_fall = 0;
        if (ign) begin
            @(posedge clk); #1; start_i = 1'b1; len_i = '0;
            @(negedge clk); chk("idle_busy0", busy_o, 0);
            @(posedge clk); #1; start_i = 1'b0;
            @(negedge clk); chk("len0_ignored", busy_o, 0);
        end
        @(posedge clk); #1; start_i = 1'b1; len_i = 16'(len);
        @(negedge clk); chk("idle_busy", busy_o, 0); s = cyc;
        for (int b = 0; b < 4000 && d < 0; b++) begin
            @(posedge clk); #1;
            start_i = ign && ($urandom_range(0, 2) == 0);
            len_i = 16'($urandom_range(1, 200));
            if (stb_at >= 0 && !stb_done && up == stb_at) begin
                stb_hold = stb_n; stb_done = 1;
            end
            cyc_i = (phase == 0 && up < len);
            stb_i = cyc_i && stb_hold == 0;
            we_i = stb_i;
            if (stb_i) dat_i = exp_q[up];
            else dat_i = 6'($urandom);
            if (stb_hold > 0 && cyc_i) stb_hold--;
            if (ack_at >= 0 && !ack_done && rx == ack_at) begin
                ack_hold = ack_n; ack_done = 1;
            end
            if (ack_hold > 0) begin
                ack_i = 1'b0; ack_hold--;
            end else begin
                ack_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            if (phase == 0) tx_cyc_i = 1'b1;
            else if (phase == 1) begin
                if (tcnt == dly) begin
                    tx_cyc_i = 1'b0; k = cyc; phase = 2;
                end
                tcnt++;
            end
            rst_now = (rst_at >= 0 && rx >= rst_at && phase == 0);
            rst_i = rst_now;
            @(negedge clk);
            if (rst_now) begin
                @(posedge clk); #1;
                rst_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0; we_i = 1'b0; start_i = 1'b0;
                @(negedge clk);
                chk("rst_cyc", cyc_o, 0);
                chk("rst_stb", stb_o, 0);
                chk("rst_ack", ack_o, 0);
                chk("rst_busy", busy_o, 0);
                chk("rst_frm", frm_cnt_o, 0);
                exp_frm = 0;
                return;
            end
            if (chk_fall) begin
                chk("cyc_fall", cyc_o, 0);
                chk("busy_drain", busy_o, 1);
                chk_fall = 0;
            end
            if (busy_o) busy_n++;
            if (phase == 0 && !cyc_o) cyc_drop = 1;
            if (ack_o && stb_i) up++;
            if (stb_o && ack_i) begin
                if (rx < tot) begin
                    chk("dat", dat_o, exp_q[rx]);
                    chk("we", we_o, 1);
                end else begin
                    chk("extra_xfer", rx + 1, tot);
                end
                rx++;
            end
            if (done_o) d = cyc;
            if (phase == 0 && rx >= tot) begin
                phase = 1; chk_fall = 1;
            end
        end
        start_i = 1'b0;
        if (d < 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("xfer_cnt", rx, tot);
            chk("up_cnt", up, len);
            chk("cyc_hold", cyc_drop, 0);
            chk("done_time", d, k + G);
            chk("busy_len", busy_n, k + G - s);
            exp_frm = (exp_frm + 1) % 65536;
            @(posedge clk); #1; start_i = 1'b0;
            @(negedge clk);
            chk("done_pulse", done_o, 0);
            chk("busy_idle", busy_o, 0);
            chk("frm_cnt", frm_cnt_o, exp_frm);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy0", busy_o, 0);
        chk("rst_cyc0", cyc_o, 0);
        chk("rst_stb0", stb_o, 0);
        chk("rst_ack0", ack_o, 0);
        chk("rst_done0", done_o, 0);
        chk("rst_dat0", dat_o, 0);
        chk("rst_frm0", frm_cnt_o, 0);
        @(posedge clk); #1; rst_i = 1'b0; w_rst = 1'b0;

        run_frame(96, -1, 0, -1, 0, -1, 0, 0);
        run_frame(100, -1, 0, -1, 0, -1, 0, 0);
        run_frame(48, -1, 0, -1, 0, -1, 0, 0);
        run_frame(60, 20, 7, 50, 3, -1, 0, 0);
        run_frame(96, -1, 0, -1, 0, -1, 1, 0);
        run_frame(64, -1, 0, -1, 0, 30, 0, 0);
        run_frame(48, -1, 0, -1, 0, -1, 0, 0);
        for (int r = 0; r < 4; r++) begin
            run_frame($urandom_range(1, 130), -1, 0, -1, 0, -1, 0, 1);
        end

        for (int f = 1; f <= 17; f++) begin
            @(posedge clk); #1; w_start = 1'b1; w_len = 4'd1; w_stb = 1'b0; w_tx = 1'b0;
            @(posedge clk); #1; w_start = 1'b0; w_stb = 1'b1; w_dat = 6'($urandom); w_tx = 1'b1;
            @(negedge clk); chk("w_ack", w_ack_o, 1);
            @(posedge clk); #1; w_stb = 1'b0; w_tx = 1'b0;
            @(negedge clk); chk("w_done", w_done_o, 1);
            @(posedge clk); #1;
            @(negedge clk); chk("w_frm", w_frm_o, f % 16);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
